// File: rtl/alu_seq_exec.sv
// alu_seq_exec: handshaked 16-bit ALU with iterative one-bit-per-cycle shifts and rotates
module alu_seq_exec (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  input  logic [3:0]  Op,
  input  logic        invA,
  input  logic        invB,
  input  logic        sign,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Out,
  output logic        Ofl,
  output logic        Z,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d, out_q, out_d, res, a_in, b_in;
  logic [3:0]  op_q, op_d, cnt_q, cnt_d;
  logic        cin_q, cin_d, sign_q, sign_d, ofl_q, ofl_d, z_q, z_d, lt, eq;
  logic [16:0] sum;
  assign a_in      = invA ? ~A : A;
  assign b_in      = invB ? ~B : B;
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign Out       = out_q;
  assign Ofl       = ofl_q;
  assign Z         = z_q;
  // shift/rotate ops leave their result in a_q, so the default arm serves ops 0-3 and F
  always_comb begin
    sum = {1'b0, a_q} + {1'b0, b_q} + {16'h0, cin_q};
    eq  = a_q == b_q;
    lt  = sign_q ? ($signed(a_q) < $signed(b_q)) : (a_q < b_q);
    case (op_q)
      4'h4:    res = sum[15:0];
      4'h5:    res = a_q | b_q;
      4'h6:    res = a_q ^ b_q;
      4'h7:    res = a_q & b_q;
      4'h8:    res = {<<{a_q}};
      4'h9:    res = {15'h0, eq};
      4'hA:    res = {15'h0, lt};
      4'hB:    res = {15'h0, lt | eq};
      4'hC:    res = {15'h0, sum[16]};
      4'hD:    res = b_q;
      4'hE:    res = {a_q[7:0], b_q[7:0]};
      default: res = a_q;
    endcase
  end
  // every accepted op spends one cycle in SHIFT with a zero count before producing its result
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    op_d    = op_q;
    sign_d  = sign_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    ofl_d   = ofl_q;
    z_d     = z_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a_in;
        b_d     = b_in;
        cin_d   = Cin;
        op_d    = Op;
        sign_d  = sign;
        cnt_d   = (Op[3:2] == 2'b00) ? b_in[3:0] : 4'h0;
        state_d = SHIFT;
      end
      SHIFT: if (cnt_q != 4'h0) begin
        a_d   = op_q[1] ? {op_q[0] ? 1'b0 : a_q[0], a_q[15:1]}
                        : {a_q[14:0], op_q[0] ? 1'b0 : a_q[15]};
        cnt_d = cnt_q - 4'h1;
      end else begin
        out_d   = res;
        ofl_d   = (op_q == 4'h4) & (sign_q ? (a_q[15] == b_q[15]) & (sum[15] != a_q[15]) : sum[16]);
        z_d     = res == 16'h0;
        state_d = DONE;
      end
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      op_q    <= '0;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      ofl_q   <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ofl_q   <= ofl_d;
      z_q     <= z_d;
    end
  end
endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: randomized scoreboard bench for alu_seq_exec against an arithmetic reference model
module tb_alu_seq_exec;
  logic        clk = 0, rst = 1, in_valid = 0, Cin = 0, invA = 0, invB = 0, sign = 0, out_ready = 0;
  logic [15:0] A = 0, B = 0;
  logic [3:0]  Op = 0;
  logic        in_ready, out_valid, Ofl, Z, busy;
  logic [15:0] Out;
  int n_chk = 0, n_fail = 0, cyc = 0, or_mode = 0;

  typedef struct {logic [15:0] out; logic ofl; logic z; int lat; int acc;} exp_t;
  exp_t q[$];

  alu_seq_exec dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
                    .Cin(Cin), .Op(Op), .invA(invA), .invB(invB), .sign(sign), .out_valid(out_valid),
                    .out_ready(out_ready), .Out(Out), .Ofl(Ofl), .Z(Z), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // consumer: random backpressure unless a directed test pins out_ready
  always begin
    @(posedge clk);
    #2;
    out_ready = (or_mode == 0) ? ($urandom_range(0, 3) != 0) : (or_mode == 2);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                 input logic [3:0] op, input logic ia, input logic ib, input logic s);
    exp_t e;
    logic [15:0] x, y;
    int k, ux, uy, sx, sy, vx, vy;
    x  = ia ? ~a : a;
    y  = ib ? ~b : b;
    k  = int'(y[3:0]);
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    vx = s ? sx : ux;
    vy = s ? sy : uy;
    e.out = 16'h0;
    e.ofl = 1'b0;
    e.acc = 0;
    e.lat = (op < 4 && k != 0) ? k + 1 : 1;
    case (op)
      4'h0: e.out = 16'((ux << k) | (ux >> (16 - k)));
      4'h1: e.out = 16'(ux << k);
      4'h2: e.out = 16'((ux >> k) | (ux << (16 - k)));
      4'h3: e.out = 16'(ux >> k);
      4'h4: begin
        e.out = 16'(ux + uy + int'(cin));
        e.ofl = s ? (sx + sy + int'(cin) > 32767 || sx + sy + int'(cin) < -32768)
                  : (ux + uy + int'(cin) > 65535);
      end
      4'h5: e.out = x | y;
      4'h6: e.out = x ^ y;
      4'h7: e.out = x & y;
      4'h8: for (int i = 0; i < 16; i++) e.out[i] = x[15 - i];
      4'h9: e.out = 16'(x == y);
      4'hA: e.out = 16'(vx < vy);
      4'hB: e.out = 16'(vx <= vy);
      4'hC: e.out = 16'(ux + uy + int'(cin) > 65535);
      4'hD: e.out = y;
      4'hE: e.out = {x[7:0], y[7:0]};
      default: e.out = x;
    endcase
    e.z = e.out == 16'h0;
    return e;
  endfunction

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c, input logic [3:0] op,
                       input logic ia, input logic ib, input logic s, output int acc);
    exp_t e;
    int n = 0;
    @(negedge clk);
    A = a; B = b; Cin = c; Op = op; invA = ia; invB = ib; sign = s; in_valid = 1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", {31'h0, in_ready}, 32'h1);
    if (!in_ready) begin
      in_valid = 0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    e = model(a, b, c, op, ia, ib, s);
    e.acc = acc;
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 0;
    A = 16'($urandom); B = 16'($urandom); Op = 4'($urandom); Cin = 1'($urandom);
    invA = 1'($urandom); invB = 1'($urandom); sign = 1'($urandom);
  endtask

  // monitor: compares the head of the scoreboard whenever a response is presented
  initial begin
    exp_t e;
    bit seen = 0;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_response: got Out=%h expected no response", Out);
        end else begin
          e = q[0];
          if (!seen) begin
            seen = 1;
            chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            chk("out", {16'h0, Out}, {16'h0, e.out});
            chk("ofl", {31'h0, Ofl}, {31'h0, e.ofl});
            chk("z", {31'h0, Z}, {31'h0, e.z});
            chk("in_ready_low", {31'h0, in_ready}, 32'h0);
          end else
            chk("hold", {14'h0, Ofl, Z, Out}, {14'h0, e.ofl, e.z, e.out});
          if (out_ready) begin
            void'(q.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  logic [15:0] da  [13] = '{16'h8001, 16'h8001, 16'hF000, 16'h7FFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                            16'h00FF, 16'h0001, 16'h12AB, 16'hFFFF, 16'h1234, 16'h8001};
  logic [15:0] db  [13] = '{16'h0004, 16'h0004, 16'h000F, 16'h0001, 16'h0001, 16'h0000, 16'h0000,
                            16'hFF00, 16'h0000, 16'h34CD, 16'h0000, 16'h0010, 16'h000F};
  logic [3:0]  dop [13] = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h4, 4'hA, 4'hA, 4'h9, 4'h8, 4'hE, 4'hC, 4'h1, 4'h0};
  logic        dcin[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  logic        dia [13] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
  logic        ds  [13] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    int acc, rel, n;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_out", {13'h0, Ofl, Z, busy, Out}, 32'h0);
    rst = 0;
    // reset during the third SHIFT cycle of a rotate by 15
    @(negedge clk);
    A = 16'h8001; B = 16'h000F; Op = 4'h0; Cin = 0; invA = 0; invB = 0; sign = 0; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (2) @(negedge clk);
    chk("mid_shift_busy", {31'h0, busy}, 32'h1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_out", {16'h0, Out}, 32'h0);
    for (int i = 0; i < 13; i++) issue(da[i], db[i], dcin[i], dop[i], dia[i], 1'b0, ds[i], acc);
    for (int i = 0; i < 150; i++)
      issue(16'($urandom), ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom), 1'($urandom),
            4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), acc);
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    // backpressure: result held, second request blocked until one cycle after the handshake
    or_mode = 1;
    issue(16'h1234, 16'h00F0, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, acc);
    @(negedge clk);
    A = 16'h5555; B = 16'h0F0F; Op = 4'h7; invA = 0; invB = 0; sign = 0; Cin = 0; in_valid = 1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
      chk("bp_out_valid", {31'h0, out_valid}, 32'h1);
      chk("bp_out", {16'h0, Out}, 32'h12C4);
    end
    rel = cyc;
    or_mode = 2;
    issue(16'h5555, 16'h0F0F, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, acc);
    chk("bp_accept_edge", 32'(acc), 32'(rel + 3));
    or_mode = 0;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
